// File: rtl/muldiv_hilo_pkg.sv
// Shared definitions for the HI/LO multiply-divide unit: divide FSM encoding,
// iteration count and opcode bit positions.
package muldiv_hilo_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } div_state_t;

  localparam int DIV_ITERS = 32;
  localparam int CNT_W     = 5;

  localparam int MULT_SIGNED   = 0;
  localparam int MULT_UNSIGNED = 1;
  localparam int DIV_SIGNED    = 0;
  localparam int DIV_UNSIGNED  = 1;
  localparam int MFHL_LO       = 0;
  localparam int MFHL_HI       = 1;
  localparam int MTHL_LO       = 0;
  localparam int MTHL_HI       = 1;

endpackage

// File: rtl/muldiv_hilo_div.sv
// Iterative unsigned restoring divider: one quotient bit per RUN cycle,
// result presented with a done pulse during the single FIX cycle.
module div_core
  import muldiv_hilo_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             cancel,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [1:0]       state,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  div_state_t       state_q, state_d;
  logic [CNT_W-1:0] count_q;
  logic [WIDTH-1:0] rem_q, quo_q, dsr_q;
  logic [WIDTH:0]   trial;

  // Bit WIDTH of the trial difference is the borrow: set means restore.
  assign trial = {rem_q, quo_q[WIDTH-1]} - {1'b0, dsr_q};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    done    = 1'b0;
    case (state_q)
      S_IDLE: if (start && !cancel) state_d = S_RUN;
      S_RUN: begin
        if (cancel) state_d = S_IDLE;
        else if (count_q == CNT_W'(DIV_ITERS - 1)) state_d = S_FIX;
      end
      S_FIX: begin
        state_d = S_IDLE;
        done    = !cancel;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_q <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dsr_q   <= '0;
    end else if (state_q == S_IDLE && start && !cancel) begin
      count_q <= '0;
      rem_q   <= '0;
      quo_q   <= dividend;
      dsr_q   <= divisor;
    end else if (state_q == S_RUN && !cancel) begin
      count_q <= count_q + 1'b1;
      if (!trial[WIDTH]) begin
        rem_q <= trial[WIDTH-1:0];
        quo_q <= {quo_q[WIDTH-2:0], 1'b1};
      end else begin
        rem_q <= {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
        quo_q <= {quo_q[WIDTH-2:0], 1'b0};
      end
    end
  end

  assign state     = state_q;
  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/muldiv_hilo.sv
// HI/LO register file with single-cycle multiply, MTHI/MTLO and a 33-cycle
// iterative divide; sign handling and divide-by-zero results live here.
module muldiv_hilo
  import muldiv_hilo_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  input  logic             cancel,
  input  logic [1:0]       MULT,
  input  logic [1:0]       DIV,
  input  logic [1:0]       MFHL,
  input  logic [1:0]       MTHL,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  output logic             busy,
  output logic [WIDTH-1:0] hilo_rdata
);

  logic [WIDTH-1:0]   hi_q, lo_q;
  logic [1:0]         div_state;
  logic               accept, do_div, do_mult, do_mt;
  logic               div_signed, div_done;
  logic [WIDTH-1:0]   rs_abs, rt_abs;
  logic [WIDTH-1:0]   quotient, remainder, q_fix, r_fix;
  logic               neg_q_q, neg_r_q, zero_q;
  logic [WIDTH-1:0]   dvd_raw_q;
  logic [2*WIDTH-1:0] a_ext, b_ext, product;
  logic               mflo_unused;

  assign busy    = (div_state != S_IDLE);
  assign accept  = in_valid && !cancel && !busy;
  assign do_div  = accept && (DIV != 2'b00);
  assign do_mult = accept && (DIV == 2'b00) && (MULT != 2'b00);
  assign do_mt   = accept && (DIV == 2'b00) && (MULT == 2'b00) && (MTHL != 2'b00);

  assign div_signed = DIV[DIV_SIGNED];
  assign rs_abs = (div_signed && rs_data[WIDTH-1]) ? -rs_data : rs_data;
  assign rt_abs = (div_signed && rt_data[WIDTH-1]) ? -rt_data : rt_data;

  assign a_ext = MULT[MULT_SIGNED] ? {{WIDTH{rs_data[WIDTH-1]}}, rs_data}
                                   : {{WIDTH{1'b0}}, rs_data};
  assign b_ext = MULT[MULT_SIGNED] ? {{WIDTH{rt_data[WIDTH-1]}}, rt_data}
                                   : {{WIDTH{1'b0}}, rt_data};
  assign product = a_ext * b_ext;

  div_core #(.WIDTH(WIDTH)) u_div (
    .clk       (clk),
    .resetn    (resetn),
    .start     (do_div),
    .cancel    (cancel),
    .dividend  (rs_abs),
    .divisor   (rt_abs),
    .state     (div_state),
    .done      (div_done),
    .quotient  (quotient),
    .remainder (remainder)
  );

  // Quotient sign is the XOR of operand signs; remainder follows the dividend.
  assign q_fix = neg_q_q ? -quotient : quotient;
  assign r_fix = neg_r_q ? -remainder : remainder;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      neg_q_q   <= 1'b0;
      neg_r_q   <= 1'b0;
      zero_q    <= 1'b0;
      dvd_raw_q <= '0;
    end else if (do_div) begin
      neg_q_q   <= div_signed && (rs_data[WIDTH-1] ^ rt_data[WIDTH-1]);
      neg_r_q   <= div_signed && rs_data[WIDTH-1];
      zero_q    <= (rt_data == '0);
      dvd_raw_q <= rs_data;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (div_done) begin
      if (zero_q) begin
        hi_q <= dvd_raw_q;
        lo_q <= '1;
      end else begin
        hi_q <= r_fix;
        lo_q <= q_fix;
      end
    end else if (do_mult) begin
      hi_q <= product[2*WIDTH-1:WIDTH];
      lo_q <= product[WIDTH-1:0];
    end else if (do_mt) begin
      if (MTHL[MTHL_HI]) hi_q <= rs_data;
      if (MTHL[MTHL_LO]) lo_q <= rs_data;
    end
  end

  // LO is the default read source, so the mflo bit itself selects nothing.
  assign mflo_unused = MFHL[MFHL_LO];
  assign hilo_rdata  = MFHL[MFHL_HI] ? hi_q : lo_q;

endmodule

// File: tb/tb_muldiv_hilo.sv
// Directed bench for muldiv_hilo: multiply, MT, divide (signed, unsigned,
// zero divisor, overflow), cancel, ignored ops while busy and reset abort.
module tb_muldiv_hilo;

  logic        clk = 1'b0;
  logic        resetn;
  logic        in_valid, cancel;
  logic [1:0]  MULT, DIV, MFHL, MTHL;
  logic [31:0] rs_data, rt_data;
  logic        busy;
  logic [31:0] hilo_rdata;

  int tests_run    = 0;
  int tests_failed = 0;

  muldiv_hilo #(.WIDTH(32)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .in_valid   (in_valid),
    .cancel     (cancel),
    .MULT       (MULT),
    .DIV        (DIV),
    .MFHL       (MFHL),
    .MTHL       (MTHL),
    .rs_data    (rs_data),
    .rt_data    (rt_data),
    .busy       (busy),
    .hilo_rdata (hilo_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0;
    cancel   = 1'b0;
    MULT     = 2'b00;
    DIV      = 2'b00;
    MTHL     = 2'b00;
    rs_data  = '0;
    rt_data  = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one op for a single cycle; returns one time unit after its edge.
  task automatic issue(input logic [1:0] mult, input logic [1:0] div,
                       input logic [1:0] mthl, input logic [31:0] rs, input logic [31:0] rt);
    in_valid = 1'b1;
    MULT     = mult;
    DIV      = div;
    MTHL     = mthl;
    rs_data  = rs;
    rt_data  = rt;
    step();
    idle_inputs();
  endtask

  task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo);
    MFHL = 2'b10;
    #1 hi = hilo_rdata;
    MFHL = 2'b01;
    #1 lo = hilo_rdata;
    MFHL = 2'b00;
  endtask

  task automatic wait_busy(output int n);
    n = 0;
    while (busy && n < 100) begin
      n++;
      step();
    end
  endtask

  task automatic check_hilo(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    logic [31:0] hi, lo;
    read_hilo(hi, lo);
    check({tag, ".hi"}, hi, exp_hi);
    check({tag, ".lo"}, lo, exp_lo);
  endtask

  task automatic run_div(input string tag, input logic [1:0] div, input logic [31:0] rs,
                         input logic [31:0] rt, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int n;
    issue(2'b00, div, 2'b00, rs, rt);
    wait_busy(n);
    check({tag, ".busy_cycles"}, 32'(n), 32'd33);
    check_hilo(tag, exp_hi, exp_lo);
  endtask

  initial begin
    int n;
    idle_inputs();
    MFHL   = 2'b00;
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset.busy", {31'b0, busy}, 32'd0);
    check_hilo("reset", 32'h0, 32'h0);
    resetn = 1'b1;
    step();

    // Multiply: signed and unsigned, single cycle, no busy.
    issue(2'b01, 2'b00, 2'b00, 32'hFFFF_FFFE, 32'd3);
    check("mult.busy", {31'b0, busy}, 32'd0);
    check_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    issue(2'b10, 2'b00, 2'b00, 32'hFFFF_FFFE, 32'd3);
    check_hilo("multu", 32'h0000_0002, 32'hFFFF_FFFA);

    // MTLO / MTHI leave the other register alone.
    issue(2'b00, 2'b00, 2'b01, 32'h0000_1111, 32'h0);
    check_hilo("mtlo", 32'h0000_0002, 32'h0000_1111);
    issue(2'b00, 2'b00, 2'b10, 32'h0000_2222, 32'h0);
    check_hilo("mthi", 32'h0000_2222, 32'h0000_1111);

    // cancel in IDLE blocks the op presented with it.
    cancel = 1'b1;
    issue(2'b00, 2'b00, 2'b01, 32'h0000_9999, 32'h0);
    check_hilo("cancel_idle", 32'h0000_2222, 32'h0000_1111);

    run_div("div_m7_2", 2'b01, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);

    // MTLO presented while busy must be ignored.
    issue(2'b00, 2'b10, 2'b00, 32'd100, 32'd7);
    in_valid = 1'b1;
    MTHL     = 2'b01;
    rs_data  = 32'h0000_AAAA;
    step();
    idle_inputs();
    check_hilo("ignored_mt", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    wait_busy(n);
    check("divu_100_7.busy_cycles", 32'(n + 1), 32'd33);
    check_hilo("divu_100_7", 32'd2, 32'd14);

    run_div("divu_by0", 2'b10, 32'd7, 32'd0, 32'h0000_0007, 32'hFFFF_FFFF);
    run_div("div_by0", 2'b01, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF);
    run_div("div_ovf", 2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
    run_div("div_7_m2", 2'b01, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD);
    run_div("divu_big", 2'b10, 32'hFFFF_FFFF, 32'd16, 32'h0000_000F, 32'h0FFF_FFFF);

    // Cancel at RUN count=10 (cycle T+11): no write then or later.
    issue(2'b00, 2'b10, 2'b00, 32'd100, 32'd7);
    repeat (10) step();
    cancel = 1'b1;
    step();
    cancel = 1'b0;
    check("cancel_run.busy", {31'b0, busy}, 32'd0);
    check_hilo("cancel_run", 32'h0000_000F, 32'h0FFF_FFFF);
    repeat (30) step();
    check_hilo("cancel_run_late", 32'h0000_000F, 32'h0FFF_FFFF);
    issue(2'b00, 2'b00, 2'b10, 32'h1234_5678, 32'h0);
    MFHL = 2'b10;
    #1 check("mfhi_after_cancel", hilo_rdata, 32'h1234_5678);
    MFHL = 2'b00;

    // Reset mid-divide clears everything and discards the divide.
    issue(2'b00, 2'b00, 2'b01, 32'h0000_0055, 32'h0);
    check_hilo("mtlo_55", 32'h1234_5678, 32'h0000_0055);
    issue(2'b00, 2'b10, 2'b00, 32'd100, 32'd7);
    repeat (5) step();
    resetn = 1'b0;
    #1;
    check("rst_run.busy", {31'b0, busy}, 32'd0);
    check_hilo("rst_run", 32'h0, 32'h0);
    step();
    resetn = 1'b1;
    repeat (40) step();
    check("rst_after.busy", {31'b0, busy}, 32'd0);
    check_hilo("rst_after", 32'h0, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
